// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared types and constants for the HUB75 scan controller: FSM states,
// colour-channel slice offsets within a packed {R, G, B} pixel, address width.
package hub75_pkg;

  localparam int ADDR_W = 14;
  localparam int B_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_U,
    FETCH_L,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DISPLAY
  } state_e;

  function automatic int r_lsb(input int bpc);
    return 2 * bpc;
  endfunction

  function automatic int g_lsb(input int bpc);
    return bpc;
  endfunction

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Read-only frame-memory port B: the scan controller is the master,
// the memory answers with data one clock after mem_re.
interface hub75_scan_ctrl_if #(
  parameter int DATA_W = 12
) ();
  import hub75_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_data;

  modport master (output mem_addr, mem_re, input mem_data);
  modport slave  (input mem_addr, mem_re, output mem_data);

endinterface

// File: rtl/hub75_scan_ctrl_bcm_timer.sv
// BCM display-window timer: loadable down-counter giving the DISPLAY length and
// the oe-on qualifier. HUB75_BRIGHTNESS_EN adds a 3-bit on-time scale.
module hub75_bcm_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [2:0]       i_brightness,
`endif
  output logic             o_last,
  output logic             o_on
);

  logic [CNT_W-1:0] r_remain;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_remain <= '0;
    end else if (i_load) begin
      r_remain <= i_len;
    end else if (r_remain != '0) begin
      r_remain <= r_remain - 1'b1;
    end
  end

  assign o_last = (r_remain == CNT_W'(1));

`ifdef HUB75_BRIGHTNESS_EN
  logic [CNT_W+2:0] w_prod;
  logic [CNT_W-1:0] w_on_len;
  logic [CNT_W-1:0] r_thresh;

  // Elapsed < on_len is the same as remaining > len - on_len.
  assign w_prod   = (CNT_W+3)'(i_len) * (CNT_W+3)'(i_brightness) + (CNT_W+3)'(i_len);
  assign w_on_len = CNT_W'(w_prod >> 3);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_thresh <= '0;
    end else if (i_load) begin
      r_thresh <= i_len - w_on_len;
    end
  end

  assign o_on = (r_remain > r_thresh);
`else
  assign o_on = (r_remain != '0);
`endif

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 BCM scan sequencer: reads pixel pairs over memory port B, shifts them out,
// latches the row and lights it for BASE_T<<plane clocks. Option: HUB75_BRIGHTNESS_EN.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 32,
  parameter int BPC     = 4,
  parameter int BPP     = 12,
  parameter int CHAINED = 1,
  parameter int CLK_DIV = 4,
  parameter int BASE_T  = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              i_en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [2:0]        i_brightness,
`endif
  hub75_scan_ctrl_if.master mem,
  output logic              o_sclk,
  output logic              o_lat,
  output logic              o_oe,
  output logic              o_a,
  output logic              o_b,
  output logic              o_c,
  output logic              o_d,
  output logic              o_r0,
  output logic              o_g0,
  output logic              o_b0,
  output logic              o_r1,
  output logic              o_g1,
  output logic              o_b1,
  output logic              o_frame_done
);

  localparam int LINE  = WIDTH * CHAINED;
  localparam int HALF  = HEIGHT / 2;
  localparam int COL_W = cw(LINE);
  localparam int ROW_W = cw(HALF);
  localparam int PL_W  = cw(BPC);
  localparam int PH_W  = cw(CLK_DIV);
  localparam int IDX_W = cw(BPP);
  localparam int CNT_W = cw((BASE_T << (BPC - 1)) + 1);
  localparam int R_LSB = r_lsb(BPC);
  localparam int G_LSB = g_lsb(BPC);

  state_e            r_state, w_state_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [PL_W-1:0]   r_plane;
  logic [PH_W-1:0]   r_phase;
  logic [BPP-1:0]    r_pix_u;
  logic [3:0]        r_row_addr;
  logic [5:0]        r_rgb;
  logic              r_frame_done;

  logic              w_phase_last, w_col_last, w_row_last, w_plane_last;
  logic              w_timer_load, w_timer_last, w_timer_on;
  logic [ADDR_W-1:0] w_addr_u, w_addr_l, w_mem_addr;
  logic              w_mem_re, w_sclk, w_lat, w_oe;
  logic [IDX_W-1:0]  w_r_idx, w_g_idx, w_b_idx;

  assign w_phase_last = (r_phase == PH_W'(CLK_DIV - 1));
  assign w_col_last   = (r_col   == COL_W'(LINE - 1));
  assign w_row_last   = (r_row   == ROW_W'(HALF - 1));
  assign w_plane_last = (r_plane == PL_W'(BPC - 1));

  assign w_addr_u = ADDR_W'(int'(r_row) * LINE + int'(r_col));
  assign w_addr_l = ADDR_W'((int'(r_row) + HALF) * LINE + int'(r_col));

  assign w_r_idx = IDX_W'(R_LSB) + IDX_W'(r_plane);
  assign w_g_idx = IDX_W'(G_LSB) + IDX_W'(r_plane);
  assign w_b_idx = IDX_W'(B_LSB) + IDX_W'(r_plane);

  assign w_timer_load = (r_state == LATCH) && w_phase_last;

  hub75_bcm_timer #(.CNT_W(CNT_W)) u_bcm_timer (
    .clk          (clk),
    .RESET        (RESET),
    .i_load       (w_timer_load),
    .i_len        (CNT_W'(BASE_T) << r_plane),
`ifdef HUB75_BRIGHTNESS_EN
    .i_brightness (i_brightness),
`endif
    .o_last       (w_timer_last),
    .o_on         (w_timer_on)
  );

  // NOTE: clocked blocks use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_mem_addr   = '0;
    w_mem_re     = 1'b0;
    w_sclk       = 1'b0;
    w_lat        = 1'b0;
    w_oe         = 1'b1;
    case (r_state)
      IDLE:     if (i_en) w_state_next = FETCH_U;
      FETCH_U: begin
        w_mem_addr   = w_addr_u;
        w_mem_re     = 1'b1;
        w_state_next = FETCH_L;
      end
      FETCH_L: begin
        w_mem_addr   = w_addr_l;
        w_mem_re     = 1'b1;
        w_state_next = LOAD;
      end
      LOAD:     w_state_next = SHIFT_LO;
      SHIFT_LO: if (w_phase_last) w_state_next = SHIFT_HI;
      SHIFT_HI: begin
        w_sclk = 1'b1;
        if (w_phase_last) w_state_next = w_col_last ? LATCH : FETCH_U;
      end
      LATCH: begin
        w_lat = 1'b1;
        if (w_phase_last) w_state_next = DISPLAY;
      end
      DISPLAY: begin
        w_oe = ~w_timer_on;
        if (w_timer_last) w_state_next = i_en ? FETCH_U : IDLE;
      end
      default:  w_state_next = IDLE;
    endcase
  end

  // Phase restarts at zero on each exit, so it is zero on entry to every timed state.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_phase <= '0;
    end else if ((r_state == SHIFT_LO || r_state == SHIFT_HI || r_state == LATCH) && !w_phase_last) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_col        <= '0;
      r_row        <= '0;
      r_plane      <= '0;
      r_row_addr   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == DISPLAY) && w_timer_last && w_plane_last && w_row_last;
      if (r_state == SHIFT_HI && w_phase_last) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) r_row_addr <= 4'(r_row);
      end
      if (r_state == DISPLAY && w_timer_last) begin
        if (w_plane_last) begin
          r_plane <= '0;
          r_row   <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_plane <= r_plane + 1'b1;
        end
      end
    end
  end

  // NOTE: pixel staging and colour registers are reset too, so the pins are defined from the first clock.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_pix_u <= '0;
      r_rgb   <= '0;
    end else if (r_state == FETCH_L) begin
      r_pix_u <= mem.mem_data;
    end else if (r_state == LOAD) begin
      r_rgb <= {r_pix_u[w_r_idx], r_pix_u[w_g_idx], r_pix_u[w_b_idx],
                mem.mem_data[w_r_idx], mem.mem_data[w_g_idx], mem.mem_data[w_b_idx]};
    end
  end

  assign mem.mem_addr = w_mem_addr;
  assign mem.mem_re   = w_mem_re;

  assign o_sclk       = w_sclk;
  assign o_lat        = w_lat;
  assign o_oe         = w_oe;
  assign {o_d, o_c, o_b, o_a} = r_row_addr;
  assign {o_r0, o_g0, o_b0, o_r1, o_g1, o_b1} = r_rgb;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Sequencer that scans the panel frame buffer through the read port (port B) of the dual-port frame memory and drives the HUB75 pins.
- Uses binary-code modulation (BCM) to show BPC-bit colour per channel.
- The host keeps exclusive use of port A. This block owns port B read-only and is the only driver of the HUB75 pins.
- Rows are scanned in pairs: row y drives r0/g0/b0, and row y+HEIGHT/2 drives r1/g1/b1.

Parameters:
- WIDTH, 96: pixels per panel row.
- HEIGHT, 32: panel rows. HEIGHT/2 must be ≤ 16 because only 4 row-address lines exist.
- BPC, 4: bits per colour channel, which is also the number of BCM planes.
- BPP, 12: bits per pixel (3*BPC). Pixel packing is {R, G, B}, with R in the MSBs.
- CHAINED, 1: number of panels in the chain. Line length is LINE = WIDTH*CHAINED.
- CLK_DIV, 4: clk cycles per sclk half-period; also the lat pulse length. Minimum 1.
- BASE_T, 8: clk cycles of oe-low for plane 0. Plane p gets BASE_T<<p cycles.

Ports:
- clk  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- en  in  1  scan enable.
- mem_addr  out  14  port B address.
- mem_re  out  1  port B read enable. Memory read data is valid exactly 1 clk after mem_re.
- mem_data  in  BPP  port B read data.
- sclk, lat, oe  out  1 each  HUB75 shift clock, latch, and output enable (oe is active-low).
- a, b, c, d  out  1 each  row address; a is the LSB.
- r0, g0, b0, r1, g1, b1  out  1 each  colour bits for the upper and lower half.
- frame_done  out  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Reset values: all outputs 0 except oe=1. State IDLE; row, plane and col counters at 0.
- Addresses:
  - upper = row*LINE + col.
  - lower = (row+HEIGHT/2)*LINE + col.
  - Both are truncated to 14 bits.
- FSM states and transitions:
  - IDLE: oe=1. Moves to FETCH_U when en=1.
  - FETCH_U (1 cycle): mem_addr=upper, mem_re=1.
  - FETCH_L (1 cycle): mem_addr=lower, mem_re=1. Registers the upper pixel.
  - LOAD (1 cycle): mem_re=0. Registers the lower pixel. r0..b1 take bit `plane` of each channel and are updated at the end of LOAD.
  - SHIFT_LO (CLK_DIV cycles): sclk=0.
  - SHIFT_HI (CLK_DIV cycles): sclk=1. Then:
    - if col < LINE-1: col++, go to FETCH_U;
    - otherwise: col=0, go to LATCH.
  - LATCH (CLK_DIV cycles): lat=1. {d,c,b,a} ← row at LATCH entry.
  - DISPLAY (BASE_T<<plane cycles): oe=0, lat=0. On exit, oe=1, then:
    - if plane < BPC-1: plane++;
    - otherwise: plane=0, and row wraps at HEIGHT/2-1 back to 0. On that wrap, frame_done=1 for the cycle after DISPLAY exit.
    - Next state is FETCH_U if en=1, otherwise IDLE.
- oe stays high in every state except DISPLAY, so no pixel is lit while shifting or latching.
- sclk is 0 in all states except SHIFT_HI.
- Cycle count per plane = LINE*(3+2*CLK_DIV) + CLK_DIV + (BASE_T<<plane).
- en=0 mid-scan: the current plane completes through DISPLAY, then the FSM goes to IDLE. Counters hold, and scanning resumes from the next plane/row when en returns to 1.
- RESET mid-operation: immediate return to reset values. A partial shift register load is discarded; the next frame overwrites it.
- mem_data is sampled only in FETCH_L and LOAD; it is ignored at all other times.

Optional Feature:
- HUB75_BRIGHTNESS_EN defined:
  - Adds input port brightness [2:0].
  - In DISPLAY, oe=0 only while the DISPLAY cycle count is below ((BASE_T<<plane)*(brightness+1))>>3. oe=1 for the rest of the window.
  - DISPLAY duration is unchanged. brightness=7 gives full on-time.
- Not defined: no brightness port; oe=0 for the whole DISPLAY window.

Decomposition:
- Shared package hub75_pkg contains:
  - state enum (IDLE, FETCH_U, FETCH_L, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY);
  - channel slice offsets (R_LSB=2*BPC, G_LSB=BPC, B_LSB=0);
  - ADDR_W=14.
- One sub-module, hub75_bcm_timer: a loadable down-counter that generates the DISPLAY window length and the brightness-gated oe. Phase counting for CLK_DIV stays in the top level.

Test Plan (WIDTH=4, HEIGHT=4, CHAINED=1, BPC=2, BPP=6, CLK_DIV=1, BASE_T=2, model memory with 1-cycle read latency):
- RESET held, then released with en=0 → oe=1, all other outputs 0, mem_re=0 indefinitely.
- en=1 with memory mem[i]=i → mem_addr sequence for row 0 is 0,8,1,9,2,10,3,11. Correction: lower = (0+2)*4 + col, so the sequence is 0,8,1,9,2,10,3,11 → must read 0,8,1,9,2,10,3,11 as pairs (upper=col, lower=8+col... with LINE=4 lower=col+8).
- All pixels = 6'b11_00_01 (R=3, G=0, B=1) → on each sclk rising edge:
  - plane 0: r0=r1=1, g0=g1=0, b0=b1=1;
  - plane 1: r=1, g=0, b=0.
  - Exactly 4 sclk pulses per plane.
- Timing check → lat high 1 cycle after the 4th sclk; oe low exactly 2 cycles for plane 0 and 4 cycles for plane 1; {d,c,b,a}=0 then 1 for the second row.
- Free run → frame_done pulses every 96 clk cycles (2 rows × (2×21 + 2 + 4)).
- Drop en during plane 0 shifting → plane 0 DISPLAY still completes (2 cycles oe=0), then IDLE with oe=1. Re-asserting en resumes at plane 1, row 0.
